// File: rtl/lagarto_fp_norm.sv
// Two-stage mantissa normalizer: S1 captures the operand and counts leading zeros,
// S2 shifts the leading one to bit 63, clamping the shift so the exponent stays >= EXP_MIN.

module lagarto_fp_norm_lzc8 (
  input  logic [7:0] d,
  output logic [2:0] cnt,
  output logic       zero
);
  // Ascending scan so the highest set bit is the last to write cnt.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < 8; i++)
      if (d[i]) cnt = 3'(7 - i);
  end

  assign zero = ~|d;
endmodule

module lagarto_fp_norm #(
  parameter int EXP_W   = 13,
  parameter int EXP_MIN = 1
) (
  input  logic             clk,
  input  logic             rsn,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [63:0]      mant_i,
  input  logic [EXP_W-1:0] exp_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [63:0]      mant_o,
  output logic [EXP_W-1:0] exp_o,
  output logic [5:0]       shamt_o,
  output logic             zero_o,
  output logic             tiny_o
);
  localparam int GRPS = 8;
  localparam logic [EXP_W:0] EMIN_W = (EXP_W+1)'(EXP_MIN);

  logic [2:1] vld_pipe;
  logic       s2_en, s1_to_s2, in_xfer;

  // ---------------- S1: leading-zero tree over 8-bit groups ----------------
  logic [GRPS-1:0][7:0] grp;
  logic [GRPS-1:0][2:0] grp_cnt;
  logic [GRPS-1:0]      grp_zero;
  logic [5:0]           in_lzc;
  logic                 in_zero;

  assign grp = mant_i;

  for (genvar g = 0; g < GRPS; g++) begin : g_lzc
    lagarto_fp_norm_lzc8 u_lzc8 (
      .d    (grp[g]),
      .cnt  (grp_cnt[g]),
      .zero (grp_zero[g])
    );
  end

  // grp[7] holds the top byte; the highest non-empty group wins.
  always_comb begin
    in_lzc = '0;
    for (int g = 0; g < GRPS; g++)
      if (!grp_zero[g]) in_lzc = {3'(GRPS - 1 - g), grp_cnt[g]};
  end

  assign in_zero = &grp_zero;

  logic [63:0]      s1_mant;
  logic [EXP_W-1:0] s1_exp;
  logic [5:0]       s1_lzc;
  logic             s1_zero;

  // ---------------- handshake ----------------
  assign s2_en    = ~vld_pipe[2] | ready_i;
  assign s1_to_s2 = vld_pipe[1] & s2_en;
  assign ready_o  = ~vld_pipe[1] | s2_en;
  assign in_xfer  = valid_i & ready_o;

  always_ff @(posedge clk or negedge rsn) begin
    if (!rsn) begin
      vld_pipe <= '0;
    end else if (flush_i) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= in_xfer | (vld_pipe[1] & ~s1_to_s2);
      vld_pipe[2] <= s1_to_s2 | (vld_pipe[2] & ~ready_i);
    end
  end

  always_ff @(posedge clk or negedge rsn) begin
    if (!rsn) begin
      s1_mant <= '0;
      s1_exp  <= '0;
      s1_lzc  <= '0;
      s1_zero <= 1'b0;
    end else if (in_xfer) begin
      s1_mant <= mant_i;
      s1_exp  <= exp_i;
      s1_lzc  <= in_lzc;
      s1_zero <= in_zero;
    end
  end

  // ---------------- S2: clamp, shift, adjust ----------------
  logic [EXP_W:0] allow_w;
  logic [5:0]     allow6, shamt;
  logic           clip;

  assign allow_w = {s1_exp[EXP_W-1], s1_exp} - EMIN_W;

  // Negative headroom means no shift at all; anything past 63 cannot limit a 64-bit shift.
  always_comb begin
    if (allow_w[EXP_W])              allow6 = 6'd0;
    else if (|allow_w[EXP_W-1:6])    allow6 = 6'd63;
    else                             allow6 = allow_w[5:0];
  end

  assign clip  = s1_lzc > allow6;
  assign shamt = s1_zero ? 6'd0 : (clip ? allow6 : s1_lzc);

  always_ff @(posedge clk or negedge rsn) begin
    if (!rsn) begin
      mant_o  <= '0;
      exp_o   <= '0;
      shamt_o <= '0;
      zero_o  <= 1'b0;
      tiny_o  <= 1'b0;
    end else if (s1_to_s2) begin
      mant_o  <= s1_mant << shamt;
      exp_o   <= s1_exp - {{(EXP_W-6){1'b0}}, shamt};
      shamt_o <= shamt;
      zero_o  <= s1_zero;
      tiny_o  <= ~s1_zero & clip;
    end
  end

  assign valid_o = vld_pipe[2];
endmodule

// File: tb/tb_lagarto_fp_norm.sv
// Directed and randomized checks of lagarto_fp_norm against an arithmetic reference model.

module tb_lagarto_fp_norm;
  localparam int EXP_W   = 13;
  localparam int EXP_MIN = 1;

  logic             clk = 1'b0;
  logic             rsn = 1'b0;
  logic             flush_i = 1'b0;
  logic             valid_i = 1'b0;
  logic             ready_o;
  logic [63:0]      mant_i = '0;
  logic [EXP_W-1:0] exp_i = '0;
  logic             valid_o;
  logic             ready_i = 1'b0;
  logic [63:0]      mant_o;
  logic [EXP_W-1:0] exp_o;
  logic [5:0]       shamt_o;
  logic             zero_o;
  logic             tiny_o;

  lagarto_fp_norm #(.EXP_W(EXP_W), .EXP_MIN(EXP_MIN)) dut (
    .clk(clk), .rsn(rsn), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .mant_i(mant_i), .exp_i(exp_i), .valid_o(valid_o), .ready_i(ready_i),
    .mant_o(mant_o), .exp_o(exp_o), .shamt_o(shamt_o), .zero_o(zero_o), .tiny_o(tiny_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0]      mant;
    logic [EXP_W-1:0] ex;
    logic [5:0]       sh;
    logic             z;
    logic             t;
  } res_t;

  res_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  logic in_x;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Leading one found by plain scan, shift limited by exponent headroom.
  function automatic res_t model(input logic [63:0] m, input logic signed [EXP_W-1:0] e);
    res_t r;
    int lz, allow, sh;
    r.mant = '0; r.ex = e; r.sh = '0; r.z = 1'b1; r.t = 1'b0;
    if (m != 0) begin
      lz = 0;
      while (!m[63 - lz]) lz++;
      allow = int'(e) - EXP_MIN;
      if (allow < 0)  allow = 0;
      if (allow > 63) allow = 63;
      sh = (lz < allow) ? lz : allow;
      r.mant = m << sh;
      r.ex   = EXP_W'(int'(e) - sh);
      r.sh   = 6'(sh);
      r.z    = 1'b0;
      r.t    = lz > allow;
    end
    return r;
  endfunction

  // One clock: sample just after the negedge drive, score transfers, advance.
  task automatic tick();
    res_t e;
    #1;
    in_x = valid_i && ready_o && !flush_i;
    if (rsn) chk("ready_o", 64'(ready_o), 64'(q.size() < 2 || ready_i));
    if (valid_o && ready_i && !flush_i) begin
      chk("out_expected", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("mant_o",  mant_o,        e.mant);
        chk("exp_o",   64'(exp_o),    64'(e.ex));
        chk("shamt_o", 64'(shamt_o),  64'(e.sh));
        chk("zero_o",  64'(zero_o),   64'(e.z));
        chk("tiny_o",  64'(tiny_o),   64'(e.t));
      end
    end
    if (flush_i) q.delete();
    else if (in_x) q.push_back(model(mant_i, exp_i));
    @(negedge clk);
  endtask

  task automatic send1(input logic [63:0] m, input logic [EXP_W-1:0] e);
    valid_i = 1'b1; mant_i = m; exp_i = e; ready_i = 1'b1;
    tick();
    valid_i = 1'b0;
    chk("lat_c1_valid", 64'(valid_o), 64'd0);
    tick();
    chk("lat_c2_valid", 64'(valid_o), 64'd1);
  endtask

  logic [63:0] ent [4];
  int idx;
  logic [63:0] rm;

  initial begin
    // reset state
    #2;
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_mant",  mant_o, 64'd0);
    chk("rst_misc",  64'({exp_o, shamt_o, zero_o, tiny_o}), 64'd0);
    @(negedge clk);
    rsn = 1'b1;
    #1;
    chk("rst_ready", 64'(ready_o), 64'd1);
    @(negedge clk);

    // basic normalize
    send1(64'h1, EXP_W'(100));
    chk("basic_mant",  mant_o, 64'h8000_0000_0000_0000);
    chk("basic_exp",   64'(exp_o), 64'd37);
    chk("basic_shamt", 64'(shamt_o), 64'd63);
    chk("basic_flags", 64'({zero_o, tiny_o}), 64'd0);
    tick();

    // clamp to subnormal
    send1(64'h0000_1000_0000_0000, EXP_W'(5));
    chk("clamp_shamt", 64'(shamt_o), 64'd4);
    chk("clamp_exp",   64'(exp_o), 64'd1);
    chk("clamp_mant",  mant_o, 64'h0001_0000_0000_0000);
    chk("clamp_tiny",  64'(tiny_o), 64'd1);
    tick();

    // zero input
    send1(64'h0, EXP_W'(-7));
    chk("zero_flag",  64'(zero_o), 64'd1);
    chk("zero_mant",  mant_o, 64'd0);
    chk("zero_exp",   64'(exp_o), 64'h1FF9);
    chk("zero_shamt", 64'(shamt_o), 64'd0);
    tick();

    // already normal, negative exponent
    send1(64'h8000_0000_0000_0000, EXP_W'(-20));
    chk("norm_shamt", 64'(shamt_o), 64'd0);
    chk("norm_tiny",  64'(tiny_o), 64'd0);
    tick();

    // backpressure: 4 entries, downstream stalled for the first 6 cycles
    ent[0] = 64'h1; ent[1] = 64'h0000_1000_0000_0000; ent[2] = 64'h00FF_0000_0000_0000; ent[3] = 64'h0;
    idx = 0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      if (cyc >= 2 && cyc <= 5) begin
        chk("bp_ready_low",  64'(ready_o), 64'd0);
        chk("bp_hold_valid", 64'(valid_o), 64'd1);
        chk("bp_hold_mant",  mant_o, 64'h8000_0000_0000_0000);
        chk("bp_hold_exp",   64'(exp_o), 64'd37);
      end
      ready_i = (cyc >= 6);
      valid_i = (idx < 4);
      mant_i  = ent[idx % 4];
      exp_i   = EXP_W'(100 + idx);
      tick();
      if (in_x) idx++;
    end
    valid_i = 1'b0;
    chk("bp_all_accepted", 64'(idx), 64'd4);
    chk("bp_all_delivered", 64'(q.size()), 64'd0);

    // flush: fill both stages, then flush together with a new input
    ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      valid_i = 1'b1; mant_i = 64'h0000_0000_00F0_0000 << i; exp_i = EXP_W'(50);
      tick();
    end
    flush_i = 1'b1; mant_i = 64'h1234;
    tick();
    flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("flush_no_valid", 64'(valid_o), 64'd0);
      tick();
    end

    // async reset while stalled full
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      valid_i = 1'b1; mant_i = 64'h0000_0F00_0000_0000; exp_i = EXP_W'(30);
      tick();
    end
    valid_i = 1'b0;
    chk("pre_rst_full", 64'(ready_o), 64'd0);
    #2 rsn = 1'b0;
    #1;
    chk("arst_valid", 64'(valid_o), 64'd0);
    chk("arst_mant",  mant_o, 64'd0);
    chk("arst_misc",  64'({exp_o, shamt_o, zero_o, tiny_o}), 64'd0);
    q.delete();
    @(negedge clk);
    rsn = 1'b1;
    send1(64'h0000_0000_0000_0F00, EXP_W'(-3));
    tick();

    // randomized traffic
    for (int cyc = 0; cyc < 600; cyc++) begin
      rm = {$urandom, $urandom};
      rm = rm >> $urandom_range(0, 63);
      if ($urandom_range(0, 15) == 0) rm = '0;
      mant_i  = rm;
      exp_i   = ($urandom_range(0, 1) == 0) ? EXP_W'($urandom)
                                            : EXP_W'(int'($urandom_range(0, 90)) - 10);
      valid_i = ($urandom_range(0, 3) != 0);
      ready_i = ($urandom_range(0, 3) != 0);
      flush_i = ($urandom_range(0, 40) == 0);
      tick();
    end
    flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    for (int i = 0; i < 6 && q.size() != 0; i++) tick();
    chk("drain_empty", 64'(q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
